// File: rtl/count_bcd_display.sv
// Binary-to-BCD converter using a one-bit-per-clock double-dabble engine.
// Drives registered BCD digits and active-low seven-segment patterns.
module count_bcd_display #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int BLANK  = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [WIDTH-1:0]      count_i,
  input  logic                  force_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [7*DIGITS-1:0]   seg_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam int SW = 7 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] last_q;
  logic [BW-1:0]   scr_q;
  logic [CW-1:0]   cnt_q;
  logic [BW-1:0]   bcd_q;
  logic [SW-1:0]   seg_q;
  logic            busy_q;
  logic            done_q;

  logic [BW-1:0]    adj;
  logic [BW-1:0]    scr_d;
  logic [WIDTH-1:0] sh_d;
  logic [SW-1:0]    seg_d;
  logic             start;

  // Active-low g..a pattern for one decimal digit.
  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  // Display pattern for an all-zero value (units shows "0").
  function automatic logic [SW-1:0] seg_reset();
    logic [SW-1:0] r;
    r = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (k == 0 || BLANK == 0) begin
        r[7*k +: 7] = 7'b1000000;
      end
    end
    return r;
  endfunction

  assign start = (count_i != last_q) | force_i;

  // Add-3 correction on every scratch digit >= 5, then the joint left shift.
  always_comb begin
    adj = scr_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scr_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
      end
    end
    scr_d = {adj[BW-2:0], sh_q[WIDTH-1]};
    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
  end

  // Segment decode of the finished scratch value with leading-zero blanking.
  always_comb begin
    logic       hi_zero;
    logic [6:0] pat;
    seg_d   = '1;
    hi_zero = 1'b1;
    pat     = 7'b1111111;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      hi_zero = hi_zero & (scr_q[4*k +: 4] == 4'd0);
      pat     = dec7(scr_q[4*k +: 4]);
      if (BLANK != 0 && k != 0 && hi_zero) begin
        pat = 7'b1111111;
      end
      seg_d[7*k +: 7] = pat;
    end
  end

  // Conversion FSM: idle until the count changes or a force arrives,
  // shift WIDTH times, then publish the result for one done cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      last_q  <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      seg_q   <= seg_reset();
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          busy_q <= start;
          if (start) begin
            sh_q    <= count_i;
            last_q  <= count_i;
            scr_q   <= '0;
            cnt_q   <= CW'(WIDTH);
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scr_q <= scr_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          bcd_q   <= scr_q;
          seg_q   <= seg_d;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bcd_o  = bcd_q;
  assign seg_o  = seg_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_count_bcd_display.sv
// Bench for count_bcd_display: blanked and unblanked instances side by side,
// expected results queued at drive time and compared on each done pulse.
module tb_count_bcd_display;

  localparam logic [6:0] SEGT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SB = 7'b1111111;

  typedef struct {
    logic [15:0] cnt;
    logic [19:0] bcd;
    logic [34:0] sg1;
    logic [34:0] sg0;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [15:0] count_i = 16'd0;
  logic        force_i = 1'b0;
  logic [19:0] bcd_b, bcd_n;
  logic [34:0] seg_b, seg_n;
  logic        busy_b, busy_n, done_b, done_n;

  int   errors = 0;
  int   checks = 0;
  vec_t sb [$];

  always #5 clk = ~clk;

  count_bcd_display #(.WIDTH(16), .DIGITS(5), .BLANK(1)) dut_b (
    .clk_i(clk), .reset_i(reset_i), .count_i(count_i), .force_i(force_i),
    .bcd_o(bcd_b), .seg_o(seg_b), .busy_o(busy_b), .done_o(done_b)
  );

  count_bcd_display #(.WIDTH(16), .DIGITS(5), .BLANK(0)) dut_n (
    .clk_i(clk), .reset_i(reset_i), .count_i(count_i), .force_i(force_i),
    .bcd_o(bcd_n), .seg_o(seg_n), .busy_o(busy_n), .done_o(done_n)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t model(input int v);
    vec_t r;
    int   q;
    int   d [5];
    logic hz;
    q     = v;
    r.cnt = v[15:0];
    r.bcd = '0;
    r.sg0 = '0;
    r.sg1 = '0;
    for (int k = 0; k < 5; k++) begin
      d[k] = q % 10;
      q    = q / 10;
      r.bcd[4*k +: 4] = 4'(d[k]);
    end
    hz = 1'b1;
    for (int k = 4; k >= 0; k--) begin
      hz = hz & (d[k] == 0);
      r.sg0[7*k +: 7] = SEGT[d[k]];
      r.sg1[7*k +: 7] = (k > 0 && hz) ? SB : SEGT[d[k]];
    end
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (done_b || done_n) begin
      vec_t e;
      if (sb.size() == 0) begin
        chk("unexpected done", 64'(done_b), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("sb bcd", 64'(bcd_b), 64'(e.bcd));
        chk("sb seg blank", 64'(seg_b), 64'(e.sg1));
        chk("sb bcd noblank", 64'(bcd_n), 64'(e.bcd));
        chk("sb seg noblank", 64'(seg_n), 64'(e.sg0));
        chk("sb done pair", 64'(done_n), 64'(done_b));
      end
    end
  end

  task automatic run_conv(input vec_t v, input bit frc, input string nm);
    int n;
    sb.push_back(v);
    count_i = v.cnt;
    force_i = frc;
    n = 0;
    do begin
      @(posedge clk); #1;
      force_i = 1'b0;
      n++;
    end while (!done_b && n < 40);
    chk({nm, " latency"}, 64'(n), 64'(18));
    chk({nm, " busy in done"}, 64'(busy_b), 64'(1));
    @(posedge clk); #1;
    chk({nm, " done low"}, 64'(done_b), 64'(0));
    chk({nm, " busy low"}, 64'(busy_b), 64'(0));
  endtask

  initial begin
    vec_t tbl [7];
    vec_t rv;
    int   n;
    logic [34:0] rst1, rst0;
    logic [15:0] v;

    rst1 = {SB, SB, SB, SB, SEGT[0]};
    rst0 = {SEGT[0], SEGT[0], SEGT[0], SEGT[0], SEGT[0]};
    tbl[0] = '{16'd35264, 20'h35264,
               {SEGT[3], SEGT[5], SEGT[2], SEGT[6], SEGT[4]},
               {SEGT[3], SEGT[5], SEGT[2], SEGT[6], SEGT[4]}};
    tbl[1] = '{16'd7, 20'h00007,
               {SB, SB, SB, SB, SEGT[7]},
               {SEGT[0], SEGT[0], SEGT[0], SEGT[0], SEGT[7]}};
    tbl[2] = '{16'd0, 20'h00000, rst1, rst0};
    tbl[3] = '{16'd10000, 20'h10000,
               {SEGT[1], SEGT[0], SEGT[0], SEGT[0], SEGT[0]},
               {SEGT[1], SEGT[0], SEGT[0], SEGT[0], SEGT[0]}};
    tbl[4] = '{16'd9, 20'h00009,
               {SB, SB, SB, SB, SEGT[9]},
               {SEGT[0], SEGT[0], SEGT[0], SEGT[0], SEGT[9]}};
    tbl[5] = '{16'd100, 20'h00100,
               {SB, SB, SEGT[1], SEGT[0], SEGT[0]},
               {SEGT[0], SEGT[0], SEGT[1], SEGT[0], SEGT[0]}};
    tbl[6] = '{16'd65535, 20'h65535,
               {SEGT[6], SEGT[5], SEGT[5], SEGT[3], SEGT[5]},
               {SEGT[6], SEGT[5], SEGT[5], SEGT[3], SEGT[5]}};

    // Reset held two cycles.
    repeat (2) @(posedge clk);
    #1;
    chk("rst bcd", 64'(bcd_b), 64'(0));
    chk("rst seg blank", 64'(seg_b), 64'(rst1));
    chk("rst seg noblank", 64'(seg_n), 64'(rst0));
    chk("rst busy", 64'(busy_b), 64'(0));
    chk("rst done", 64'(done_b), 64'(0));
    reset_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle after rst busy", 64'(busy_b), 64'(0));

    for (int i = 0; i < 7; i++) begin
      run_conv(tbl[i], 1'b0, $sformatf("tbl%0d", i));
    end

    // Force with unchanged count repeats the conversion.
    run_conv(tbl[6], 1'b1, "force");

    // Force while busy is dropped.
    sb.push_back(model(42));
    count_i = 16'd42;
    n = 0;
    do begin
      @(posedge clk); #1;
      force_i = (n == 4);
      n++;
    end while (!done_b && n < 40);
    force_i = 1'b0;
    chk("busyforce latency", 64'(n), 64'(18));
    repeat (25) @(posedge clk);
    #1;
    chk("busyforce no requeue", 64'(busy_b), 64'(0));

    // Count changed mid-conversion.
    sb.push_back(model(100));
    sb.push_back(model(200));
    count_i = 16'd100;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 5) count_i = 16'd200;
    end while (!done_b && n < 40);
    chk("midchg first latency", 64'(n), 64'(18));
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) chk("midchg restart busy", 64'(busy_b), 64'(1));
    end while (!done_b && n < 40);
    chk("midchg second latency", 64'(n), 64'(18));
    @(posedge clk); #1;
    chk("midchg done low", 64'(done_b), 64'(0));

    // Reset at edge N+8 of a conversion.
    count_i = 16'd1234;
    repeat (8) @(posedge clk);
    #1;
    chk("abort busy before", 64'(busy_b), 64'(1));
    reset_i = 1'b1;
    count_i = 16'd0;
    @(posedge clk); #1;
    chk("abort bcd", 64'(bcd_b), 64'(0));
    chk("abort seg blank", 64'(seg_b), 64'(rst1));
    chk("abort seg noblank", 64'(seg_n), 64'(rst0));
    chk("abort busy", 64'(busy_b), 64'(0));
    chk("abort done", 64'(done_b), 64'(0));
    @(posedge clk); #1;
    reset_i = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("abort stays idle", 64'(busy_b), 64'(0));

    // Random values against the arithmetic model.
    for (int i = 0; i < 4; i++) begin
      do v = 16'($urandom_range(1, 65535)); while (v == count_i);
      rv = model(int'(v));
      run_conv(rv, 1'b0, $sformatf("rand%0d", i));
    end

    chk("queue drained", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
